// File: rtl/clahe_hist_ram_bank.sv
// Histogram RAM bank for CLAHE: 64 tiles x 256 bins x 16 bit. It provides a write port and a
// 1-cycle read port with write-first bypass, clears all tiles in a 256-cycle sweep, and tracks hist_ready.
module clahe_hist_ram_bank #(
   parameter int TILE_NUM = 64,
   parameter int BINS     = 256,
   parameter int DATA_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_start,
   input  logic [5:0]        ram_wr_tile_idx,
   input  logic [7:0]        ram_wr_addr_a,
   input  logic [DATA_W-1:0] ram_wr_data_a,
   input  logic              ram_wr_en_a,
   input  logic [5:0]        ram_rd_tile_idx,
   input  logic [7:0]        ram_rd_addr_b,
   input  logic              frame_hist_done,
   output logic [DATA_W-1:0] ram_rd_data_b,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              hist_ready
);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [7:0]          r_ptr;
   logic [7:0]          w_ptr_next;
   logic                r_clear_done;
   logic                w_done_next;
   logic                r_hist_ready;
   logic [DATA_W-1:0]   r_rd_data;
   logic                w_clr_we;
   logic                w_wr_tile_ok;
   logic                w_rd_tile_ok;
   logic                w_wr_ok;
   logic                w_bypass;

   // One bank per tile so the clear sweep can zero the same bin in every tile at once.
   logic [DATA_W-1:0]   r_mem [TILE_NUM][BINS];

   assign w_wr_tile_ok = ({1'b0, ram_wr_tile_idx} < 7'(TILE_NUM));
   assign w_rd_tile_ok = ({1'b0, ram_rd_tile_idx} < 7'(TILE_NUM));
   assign w_wr_ok      = ram_wr_en_a && !w_clr_we && w_wr_tile_ok;
   assign w_bypass     = w_wr_ok && (ram_wr_tile_idx == ram_rd_tile_idx)
                                 && (ram_wr_addr_a == ram_rd_addr_b);

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_clear_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_ptr        <= w_ptr_next;
         r_clear_done <= w_done_next;
      end
   end

   // FSM: next state; a clear_start during a sweep restarts it without a done pulse
   always_comb begin
      w_state_next = r_state;
      w_ptr_next   = r_ptr;
      w_done_next  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (clear_start) begin
               w_state_next = S_CLEAR;
               w_ptr_next   = '0;
            end
         end
         S_CLEAR: begin
            if (clear_start) begin
               w_ptr_next = '0;
            end else if (r_ptr == 8'(BINS - 1)) begin
               w_state_next = S_IDLE;
               w_ptr_next   = '0;
               w_done_next  = 1'b1;
            end else begin
               w_ptr_next = r_ptr + 8'd1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_ptr_next   = '0;
         end
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_clr_we   = (r_state == S_CLEAR);
      clear_busy = (r_state == S_CLEAR);
      clear_done = r_clear_done;
   end

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         for (int t = 0; t < TILE_NUM; t++) begin
            r_mem[t][r_ptr] <= '0;
         end
      end else if (w_wr_ok) begin
         r_mem[ram_wr_tile_idx][ram_wr_addr_a] <= ram_wr_data_a;
      end
   end

   // Read data is held at zero for every cycle in which the sweep is (or is about to be) active.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data <= '0;
      end else if ((w_state_next == S_CLEAR) || (r_state == S_CLEAR) || !w_rd_tile_ok) begin
         r_rd_data <= '0;
      end else if (w_bypass) begin
         r_rd_data <= ram_wr_data_a;
      end else begin
         r_rd_data <= r_mem[ram_rd_tile_idx][ram_rd_addr_b];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hist_ready <= 1'b0;
      end else if (clear_start) begin
         r_hist_ready <= 1'b0;
      end else if (frame_hist_done && !clear_busy) begin
         r_hist_ready <= 1'b1;
      end
   end

   assign ram_rd_data_b = r_rd_data;
   assign hist_ready    = r_hist_ready;

endmodule

// File: tb/tb_clahe_hist_ram_bank.sv
// Self-checking bench for clahe_hist_ram_bank: clear sweeps, read latency and bypass,
// sweep restart, writes dropped during clear, hist_ready and reset mid-sweep.
module tb_clahe_hist_ram_bank;

   logic        clk;
   logic        rst_n;
   logic        clear_start;
   logic [5:0]  ram_wr_tile_idx;
   logic [7:0]  ram_wr_addr_a;
   logic [15:0] ram_wr_data_a;
   logic        ram_wr_en_a;
   logic [5:0]  ram_rd_tile_idx;
   logic [7:0]  ram_rd_addr_b;
   logic        frame_hist_done;
   logic [15:0] ram_rd_data_b;
   logic        clear_busy;
   logic        clear_done;
   logic        hist_ready;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_q[$];
   logic [15:0] model_mem [64][256];

   clahe_hist_ram_bank dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .clear_start     (clear_start),
      .ram_wr_tile_idx (ram_wr_tile_idx),
      .ram_wr_addr_a   (ram_wr_addr_a),
      .ram_wr_data_a   (ram_wr_data_a),
      .ram_wr_en_a     (ram_wr_en_a),
      .ram_rd_tile_idx (ram_rd_tile_idx),
      .ram_rd_addr_b   (ram_rd_addr_b),
      .frame_hist_done (frame_hist_done),
      .ram_rd_data_b   (ram_rd_data_b),
      .clear_busy      (clear_busy),
      .clear_done      (clear_done),
      .hist_ready      (hist_ready)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int t = 0; t < 64; t++)
         for (int b = 0; b < 256; b++)
            model_mem[t][b] = 16'h0000;
   endtask

   task automatic idle_inputs();
      clear_start     = 1'b0;
      frame_hist_done = 1'b0;
      ram_wr_en_a     = 1'b0;
      ram_wr_tile_idx = '0;
      ram_wr_addr_a   = '0;
      ram_wr_data_a   = '0;
   endtask

   // One bus cycle: optional write plus a read; expected read data is queued at drive time.
   task automatic drive(input logic we, input logic [5:0] wt, input logic [7:0] wa,
                        input logic [15:0] wd, input logic [5:0] rt, input logic [7:0] ra);
      logic [15:0] e;
      logic        busy_now;
      ram_wr_en_a     = we;
      ram_wr_tile_idx = wt;
      ram_wr_addr_a   = wa;
      ram_wr_data_a   = wd;
      ram_rd_tile_idx = rt;
      ram_rd_addr_b   = ra;
      busy_now        = clear_busy;
      if (busy_now)                      e = 16'h0000;
      else if (we && wt == rt && wa == ra) e = wd;
      else                               e = model_mem[rt][ra];
      exp_q.push_back(e);
      step();
      if (we && !busy_now) model_mem[wt][wa] = wd;
      ram_wr_en_a = 1'b0;
      check($sformatf("rd_data t%0d b%0d", rt, ra), ram_rd_data_b, exp_q.pop_front());
   endtask

   task automatic pulse_clear();
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
   endtask

   // Runs while clear_busy is high, writing tile 3 bin 200 and reading it every cycle.
   task automatic run_sweep(input int restart_at, input int fhd_at, input int rst_at,
                            output int n_busy, output int n_done, output int n_nz, output int n_hr);
      n_busy = 0; n_done = 0; n_nz = 0; n_hr = 0;
      while (clear_busy && n_busy < 2000) begin
         n_busy++;
         if (ram_rd_data_b != 16'h0000) n_nz++;
         if (clear_done) n_done++;
         if (hist_ready) n_hr++;
         clear_start     = (n_busy == restart_at);
         frame_hist_done = (n_busy == fhd_at);
         ram_wr_en_a     = 1'b1;
         ram_wr_tile_idx = 6'd3;
         ram_wr_addr_a   = 8'd200;
         ram_wr_data_a   = 16'hFFFF;
         ram_rd_tile_idx = 6'd3;
         ram_rd_addr_b   = 8'd200;
         if (n_busy == rst_at) begin
            rst_n = 1'b0;
            #1;
            break;
         end
         step();
      end
      idle_inputs();
   endtask

   initial begin
      int nb, nd, nz, nh;
      rst_n = 1'b0;
      idle_inputs();
      ram_rd_tile_idx = '0;
      ram_rd_addr_b   = '0;
      clear_model();
      repeat (3) step();
      check("reset rd_data", ram_rd_data_b, 16'h0000);
      check("reset clear_busy", clear_busy, 1'b0);
      check("reset clear_done", clear_done, 1'b0);
      check("reset hist_ready", hist_ready, 1'b0);
      rst_n = 1'b1;
      step();

      // First full sweep
      pulse_clear();
      check("sweep1 busy start", clear_busy, 1'b1);
      run_sweep(0, 0, 0, nb, nd, nz, nh);
      check("sweep1 busy cycles", nb, 256);
      check("sweep1 early done", nd, 0);
      check("sweep1 rd nonzero", nz, 0);
      check("sweep1 done pulse", clear_done, 1'b1);
      check("sweep1 busy end", clear_busy, 1'b0);
      step();
      check("sweep1 done one cycle", clear_done, 1'b0);
      clear_model();

      drive(0, 0, 0, 0, 6'd0, 8'd0);
      drive(0, 0, 0, 0, 6'd0, 8'd255);
      drive(0, 0, 0, 0, 6'd63, 8'd0);
      drive(0, 0, 0, 0, 6'd63, 8'd255);

      // Write then read; same-cycle bypass; other tile unaffected
      drive(1, 6'd5, 8'd10, 16'h0123, 6'd0, 8'd0);
      drive(0, 0, 0, 0, 6'd5, 8'd10);
      drive(1, 6'd6, 8'd10, 16'h0BEE, 6'd5, 8'd10);
      drive(1, 6'd5, 8'd10, 16'h0124, 6'd5, 8'd10);
      drive(1, 6'd5, 8'd10, 16'h0125, 6'd6, 8'd10);
      drive(0, 0, 0, 0, 6'd5, 8'd10);

      // Random read-modify-write traffic on a small window to hit bypass often
      for (int i = 0; i < 60; i++)
         drive(1'($urandom_range(0, 1)), 6'($urandom_range(4, 6)), 8'($urandom_range(8, 11)),
               16'($urandom), 6'($urandom_range(4, 6)), 8'($urandom_range(8, 11)));

      drive(1, 6'd3, 8'd200, 16'h5555, 6'd3, 8'd200);
      drive(1, 6'd63, 8'd255, 16'hABCD, 6'd3, 8'd200);
      drive(0, 0, 0, 0, 6'd63, 8'd255);

      // Sweep restarted on its 100th busy cycle, with writes attempted throughout
      pulse_clear();
      run_sweep(100, 0, 0, nb, nd, nz, nh);
      check("sweep2 busy cycles", nb, 356);
      check("sweep2 early done", nd, 0);
      check("sweep2 rd nonzero", nz, 0);
      check("sweep2 done pulse", clear_done, 1'b1);
      step();
      check("sweep2 done one cycle", clear_done, 1'b0);
      clear_model();
      drive(0, 0, 0, 0, 6'd3, 8'd200);
      drive(0, 0, 0, 0, 6'd63, 8'd255);
      drive(0, 0, 0, 0, 6'd5, 8'd10);

      // hist_ready set/hold, then clear wins over a simultaneous frame_hist_done
      check("hist_ready idle", hist_ready, 1'b0);
      frame_hist_done = 1'b1;
      step();
      frame_hist_done = 1'b0;
      check("hist_ready set", hist_ready, 1'b1);
      step();
      step();
      check("hist_ready hold", hist_ready, 1'b1);
      clear_start     = 1'b1;
      frame_hist_done = 1'b1;
      step();
      idle_inputs();
      check("hist_ready clear wins", hist_ready, 1'b0);
      check("sweep3 busy start", clear_busy, 1'b1);

      // frame_hist_done during the sweep is ignored; reset lands on busy cycle 60
      run_sweep(0, 20, 60, nb, nd, nz, nh);
      check("sweep3 busy before reset", nb, 60);
      check("sweep3 hist_ready during clear", nh, 0);
      check("sweep3 no done", nd, 0);
      check("async reset busy", clear_busy, 1'b0);
      check("async reset rd_data", ram_rd_data_b, 16'h0000);
      nd = 0;
      repeat (2) begin
         step();
         if (clear_done) nd++;
      end
      rst_n = 1'b1;
      repeat (4) begin
         step();
         if (clear_done || clear_busy) nd++;
      end
      check("post reset no done or busy", nd, 0);
      check("post reset hist_ready", hist_ready, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clahe_hist_ram_bank.md
Name: clahe_hist_ram_bank

Overview:
Responder/storage side of the histogram RAM interface. It holds 64 tile histograms of 256 bins x 16 bit each. The histogram accumulator drives port A writes and port B read addresses for its read-modify-write loop; this block returns read data, runs the frame-start clear sweep, and publishes histogram-ready status to the downstream CDF/clip stage.

Parameters:
TILE_NUM, 64, number of tile histograms (tile index width TW = 6)
BINS, 256, bins per tile (address width 8)
DATA_W, 16, bin counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clear_start  in  1  one-cycle pulse: start clearing all tiles
ram_wr_tile_idx  in  6  port A tile select
ram_wr_addr_a  in  8  port A bin address
ram_wr_data_a  in  16  port A write data
ram_wr_en_a  in  1  port A write strobe
ram_rd_tile_idx  in  6  port B tile select
ram_rd_addr_b  in  8  port B bin address (read every cycle)
frame_hist_done  in  1  one-cycle pulse: accumulation for the frame finished
ram_rd_data_b  out  16  port B read data, 1-cycle latency
clear_busy  out  1  clear sweep in progress
clear_done  out  1  one-cycle pulse when sweep completes
hist_ready  out  1  level: histograms complete and valid for readout

Behaviour:
- Clock/reset: clk; asynchronous active-low rst_n. Reset: ram_rd_data_b=0, clear_busy=0, clear_done=0, hist_ready=0, clear pointer=0. Memory contents are not reset and are undefined until the first clear sweep completes.
- Storage: 64 banks of 256x16, one bank per tile, so the clearer can address all banks in parallel.
- Port A write:
  - When ram_wr_en_a=1 and clear_busy=0, mem[wr_tile][wr_addr] <= ram_wr_data_a at the clock edge.
  - Out-of-range tile index (>= TILE_NUM when the parameter is < 64) is ignored.
- Port B read:
  - The address is sampled every cycle. ram_rd_data_b at cycle N+1 = mem[rd_tile][rd_addr] as of cycle N.
  - Write-first bypass: if a port A write in cycle N hits the same tile and address, ram_rd_data_b at N+1 = ram_wr_data_a. This is required for back-to-back read-modify-write on the same bin.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_start. The pointer loads 0 and clear_busy goes to 1 in the next cycle.
  - In CLEAR, each cycle writes 0 to mem[t][ptr] for all t, then ptr++.
  - At ptr=255 the last bin is written. Next cycle: state IDLE, clear_busy=0, clear_done=1 for exactly one cycle.
  - Sweep length is 256 cycles of clear_busy=1.
  - clear_start while in CLEAR restarts the sweep: ptr=0, no clear_done for the aborted sweep.
  - During CLEAR, port A writes are dropped and ram_rd_data_b is forced to 0.
- hist_ready:
  - Set on the cycle after frame_hist_done=1 while clear_busy=0.
  - Cleared on the cycle after clear_start.
  - If clear_start and frame_hist_done arrive in the same cycle, clear wins: hist_ready=0.
  - frame_hist_done during CLEAR is ignored.
- Reset mid-sweep: the FSM returns to IDLE and clear_busy=0. Contents are partially cleared and treated as undefined; no clear_done is issued.
- Counters are stored verbatim. This block does no saturation; the accumulator saturates at 16'hFFFF.

Test Plan:
- Reset then clear_start -> clear_busy=1 for exactly 256 cycles, clear_done pulses once, then reads of tile 0/63, bins 0/255 return 0.
- Write tile 5, bin 10, data 16'h0123; read the same bin the next cycle -> ram_rd_data_b=16'h0123 one cycle after the read address is presented.
- Same-cycle write tile 5, bin 10, 16'h0124 and read tile 5, bin 10 -> next-cycle ram_rd_data_b=16'h0124 (bypass). A different-tile read of bin 10 returns that tile's own value.
- clear_start at sweep cycle 100 -> sweep restarts, total clear_busy = 100+256 cycles, single clear_done.
- Write during clear_busy (tile 3, bin 200, 16'hFFFF) -> after clear_done, tile 3, bin 200 reads 0; ram_rd_data_b=0 throughout the sweep.
- frame_hist_done -> hist_ready=1. Then clear_start and frame_hist_done in the same cycle -> hist_ready=0. rst_n low mid-sweep -> clear_busy=0 immediately, no clear_done.
